inst_queue_dual: RTL
====================

Name: inst_queue_dual

Overview:
Parametrised two-in/two-out instruction queue between the fetch/ICache stage and the issue stage. It accepts 0–2 fetched instructions per cycle and presents the two oldest entries to issue, which pops 0–2 per cycle. Each entry carries the instruction word, its PC and the BPU prediction tag. An explicit occupancy counter drives exact valid, full and almost-full flags, and sticky error flags report overflow and underflow.

Parameters:
DEPTH, 32, entry count; power of 2, ≥4
INST_W, 32, instruction width
PC_W, 32, PC width
PRED_W, 33, BPU prediction info width
AF_SLACK, 4, almost_full asserts when free entries < AF_SLACK

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of queue contents
in_valid1  in  1  slot-1 fetch valid
in_valid2  in  1  slot-2 fetch valid; ignored unless in_valid1=1
in_inst1, in_inst2  in  INST_W  fetched instructions
in_pc1, in_pc2  in  PC_W  fetched PCs
in_pred  in  PRED_W  prediction info for this fetch group
in_pred_sel  in  1  0: in_pred attaches to slot 1; 1: to slot 2
pop_cnt  in  2  entries consumed by issue this cycle (0,1,2; 3 treated as 2)
out_valid1, out_valid2  out  1  head / head+1 entry valid
out_inst1, out_inst2  out  INST_W  head / head+1 instruction
out_pc1, out_pc2  out  PC_W  head / head+1 PC
out_pred1, out_pred2  out  PRED_W  head / head+1 prediction info
count  out  clog2(DEPTH)+1  current occupancy
full  out  1  count == DEPTH
almost_full  out  1  DEPTH−count < AF_SLACK; fetch stalls on this
overflow_err, underflow_err  out  1  sticky error flags

Behaviour:
- Reset (rst=0, async): head=0, tail=0, count=0, both error flags 0. All out_valid outputs 0, full=0, almost_full=0. Entry storage is not reset.
- Push count: push_n = in_valid1 + (in_valid1 & in_valid2). Slot 1 writes to tail, slot 2 to tail+1. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Pred attach: the selected slot gets in_pred. The other slot is written with PRED_W'0. If in_pred_sel=1 and push_n=1, the pred is dropped and slot 1 gets 0.
- Space check: a push is accepted only if push_n ≤ DEPTH−count+eff_pop, where eff_pop is this cycle's effective pop. Otherwise the whole group is dropped (no partial write), tail is unchanged, and overflow_err is set.
- Pop: eff_pop = min(pop_cnt clamped to 2, count). If the requested pop exceeds count, underflow_err is set. head advances by eff_pop.
- Count update: count_next = count + accepted_push − eff_pop. The counter never wraps.
- Outputs are combinational from registered state: out_valid1 = (count≥1), out_valid2 = (count≥2). Data outputs are read at head and head+1 (mod DEPTH); they are don't-care when the matching valid is 0.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no same-cycle bypass, including when the queue is empty.
- Simultaneous push and pop: both take effect in the same edge. A pop in the same cycle frees space for that cycle's push, so a full queue with pop_cnt=2 accepts 2.
- Flush: head, tail and count are cleared to 0. Flush overrides push and pop in the same cycle, and the incoming group is discarded. Error flags are not cleared by flush.
- Error flags clear only on reset.
- Wrap-around: a dual push at tail=DEPTH−1 writes entries DEPTH−1 and 0. A dual read at head=DEPTH−1 returns entries DEPTH−1 and 0.
- No state machine. State is the head and tail pointers, count and the sticky flags.

Decomposition:
- Shared package/defines: INST_W, PC_W, PRED_W defaults; pop-count encodings POP_NONE=0, POP_ONE=1, POP_TWO=2.
- Sub-module inst_queue_ram: DEPTH×(INST_W+PC_W+PRED_W) register array, two write ports and two async read ports. When the write enables are given, the two write addresses always differ.
- Top module: pointer, count, flag and accept logic.

Test Plan:
- Reset then idle → count=0, out_valid1=0, out_valid2=0, full=0; rst mid-stream with count=5 → count=0 immediately, before the next edge.
- Dual push pc 0x100/0x104, pred=0x1_0000_00AA, sel=1 → next cycle out_pc1=0x100, out_pc2=0x104, out_pred1=0, out_pred2=0x1_0000_00AA, count=2.
- Fill to 32 by dual pushes → full=1, almost_full=1 from count 29; 33rd push with pop_cnt=0 → dropped, overflow_err=1, count stays 32.
- Full queue, dual push plus pop_cnt=2 together → count stays 32, outputs advance by 2, overflow_err stays 0.
- Wrap: head=tail=31 with count=0; dual push 0xA/0xB → entries land at 31 and 0; next cycle pop_cnt=2 → count=0, head=1.
- count=1, pop_cnt=2 → count=0, underflow_err=1; flush with concurrent dual push → count=0 next cycle, err flags unchanged.

Source files
------------

// File: rtl/inst_queue_dual_pkg.sv
// Shared widths and pop-count encodings for the dual-issue instruction queue.
package inst_queue_dual_pkg;

  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int PRED_W_DEF = 33;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  // Issue may request 3; the queue only ever presents two entries.
  function automatic logic [1:0] clamp_pop(input logic [1:0] p);
    return (p > POP_TWO) ? POP_TWO : p;
  endfunction

endpackage

// File: rtl/inst_queue_dual_if.sv
// Fetch/issue-facing signal bundle of the instruction queue.
interface inst_queue_dual_if #(
  parameter int DEPTH  = 32,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int PRED_W = 33
);
  logic                     flush;
  logic                     in_valid1;
  logic                     in_valid2;
  logic [INST_W-1:0]        in_inst1;
  logic [INST_W-1:0]        in_inst2;
  logic [PC_W-1:0]          in_pc1;
  logic [PC_W-1:0]          in_pc2;
  logic [PRED_W-1:0]        in_pred;
  logic                     in_pred_sel;
  logic [1:0]               pop_cnt;

  logic                     out_valid1;
  logic                     out_valid2;
  logic [INST_W-1:0]        out_inst1;
  logic [INST_W-1:0]        out_inst2;
  logic [PC_W-1:0]          out_pc1;
  logic [PC_W-1:0]          out_pc2;
  logic [PRED_W-1:0]        out_pred1;
  logic [PRED_W-1:0]        out_pred2;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     almost_full;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
           in_pred, in_pred_sel, pop_cnt,
    input  out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
           out_pred1, out_pred2, count, full, almost_full, overflow_err, underflow_err
  );

  modport slave (
    input  flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
           in_pred, in_pred_sel, pop_cnt,
    output out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
           out_pred1, out_pred2, count, full, almost_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/inst_queue_dual_ram.sv
// Entry storage: register array with two write ports and two async read ports.
module inst_queue_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 97
) (
  input  logic                     clk,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [W-1:0]             wdata1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] waddr2,
  input  logic [W-1:0]             wdata2,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [W-1:0]             rdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [W-1:0]             rdata2
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Write addresses never collide when both enables are set.
  always_comb begin
    mem_d = mem_q;
    if (we1) mem_d[waddr1] = wdata1;
    if (we2) mem_d[waddr2] = wdata2;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/inst_queue_dual.sv
// Two-in/two-out instruction queue: pointers, occupancy, flags and accept logic.
module inst_queue_dual
  import inst_queue_dual_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int INST_W   = INST_W_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int PRED_W   = PRED_W_DEF,
  parameter int AF_SLACK = 4
) (
  input  logic             clk,
  input  logic             rst,
  inst_queue_dual_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INST_W + PC_W + PRED_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   SLACK_C = (CW+1)'(AF_SLACK);

  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [1:0]        push_n, pop_req, eff_pop, acc_push;
  logic [CW:0]       room;
  logic              push_ok, pop_short;
  logic              we1, we2;
  logic [PRED_W-1:0] pred1, pred2;
  logic [EW-1:0]     wdata1, wdata2, rdata1, rdata2;

  always_comb begin
    push_n    = q.in_valid1 ? (q.in_valid2 ? POP_TWO : POP_ONE) : POP_NONE;
    pop_req   = clamp_pop(q.pop_cnt);
    pop_short = CW'(pop_req) > count_q;
    eff_pop   = pop_short ? count_q[1:0] : pop_req;
    // Space freed by this cycle's pop is usable by this cycle's push.
    room      = {1'b0, DEPTH_C - count_q} + (CW+1)'(eff_pop);
    push_ok   = (CW+1)'(push_n) <= room;
    acc_push  = push_ok ? push_n : POP_NONE;

    pred1  = q.in_pred_sel ? '0 : q.in_pred;
    pred2  = q.in_pred_sel ? q.in_pred : '0;
    wdata1 = {q.in_inst1, q.in_pc1, pred1};
    wdata2 = {q.in_inst2, q.in_pc2, pred2};
    we1    = !q.flush && (acc_push != POP_NONE);
    we2    = !q.flush && (acc_push == POP_TWO);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(eff_pop);
      tail_d  = tail_q + AW'(acc_push);
      count_d = count_q + CW'(acc_push) - CW'(eff_pop);
      ovf_d   = ovf_q | !push_ok;
      unf_d   = unf_q | pop_short;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk    (clk),
    .we1    (we1),
    .waddr1 (tail_q),
    .wdata1 (wdata1),
    .we2    (we2),
    .waddr2 (tail_q + AW'(1)),
    .wdata2 (wdata2),
    .raddr1 (head_q),
    .rdata1 (rdata1),
    .raddr2 (head_q + AW'(1)),
    .rdata2 (rdata2)
  );

  assign {q.out_inst1, q.out_pc1, q.out_pred1} = rdata1;
  assign {q.out_inst2, q.out_pc2, q.out_pred2} = rdata2;

  assign q.out_valid1    = count_q != '0;
  assign q.out_valid2    = count_q >= CW'(2);
  assign q.count         = count_q;
  assign q.full          = count_q == DEPTH_C;
  assign q.almost_full   = {1'b0, DEPTH_C - count_q} < SLACK_C;
  assign q.overflow_err  = ovf_q;
  assign q.underflow_err = unf_q;

endmodule
